// File: rtl/tree_pkg.sv
// Shared definitions for the AND reduction tree and its feeders.
// Provides the tree input width and elaboration-time width helpers.
package tree_pkg;

    localparam int TREE_WIDTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Tree widths must be powers of two so every level halves cleanly.
    function automatic bit width_ok(input int w);
        return (w >= 2) && ((w & (w - 1)) == 0);
    endfunction

    localparam bit TREE_WIDTH_OK = width_ok(TREE_WIDTH);

endpackage

// File: rtl/tree_hold_reg.sv
// Valid/ready hold register: keeps a loaded word stable until it is consumed.
// A load on the consuming edge wins, so back-to-back words need no bubble.
module tree_hold_reg
    import tree_pkg::*;
#(
    parameter int WIDTH = TREE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tree_in_bit_deserializer.sv
// Serial-to-parallel feeder for the AND reduction tree: LSB-first bits are
// assembled into a word while the previous word waits in the hold register.
module tree_in_bit_deserializer
    import tree_pkg::*;
#(
    parameter int WIDTH = TREE_WIDTH,
    localparam int CW = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             bit_in,
    input  logic             abort,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic [CW-1:0]    fill
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH) || !TREE_WIDTH_OK) begin : g_width_check
        $error("tree_in_bit_deserializer: WIDTH must be a power of 2 and >= 2");
    end

    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] sr;
    logic             bit_accept;
    logic             word_load;

    // The last bit may only land when the hold register is free or being freed.
    assign bit_ready  = !rst && !abort && ((cnt != LAST) || !word_valid || word_ready);
    assign bit_accept = bit_valid && bit_ready;
    assign word_load  = bit_accept && (cnt == LAST);
    assign fill       = cnt;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt <= '0;
            sr  <= '0;
        end else if (word_load) begin
            cnt <= '0;
            sr  <= '0;
        end else if (bit_accept) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (cnt == CW'(i)) begin
                    sr[i] <= bit_in;
                end
            end
            cnt <= cnt + 1'b1;
        end
    end

    tree_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (word_load),
        .load_data({bit_in, sr}),
        .out_ready(word_ready),
        .out_valid(word_valid),
        .out_data (word_out)
    );

endmodule

// File: tb/tb_tree_in_bit_deserializer.sv
// Self-checking bench for tree_in_bit_deserializer: directed steps plus a
// random-gap run, with completed words tracked in a scoreboard queue.
module tb_tree_in_bit_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_valid;
    logic             bit_ready;
    logic             bit_in;
    logic             abort;
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic [2:0]       fill;

    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] sb_q[$];
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_sr = '0;
    logic             m_valid = 1'b0;
    bit               m_live = 1'b0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] held_word = '0;
    int               words_popped = 0;

    always #5 clk = ~clk;

    tree_in_bit_deserializer #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_in    (bit_in),
        .abort     (abort),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_out  (word_out),
        .fill      (fill)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model updates on the negedge before each rising edge, using the inputs then held.
    task automatic tick();
        logic m_ready;
        logic word_fire;
        logic load;
        @(negedge clk);
        m_ready = !rst && !abort && ((m_cnt != WIDTH - 1) || !m_valid || word_ready);
        if (m_live) begin
            checkOutput("bit_ready", 32'(bit_ready), 32'(m_ready));
            checkOutput("word_valid", 32'(word_valid), 32'(m_valid));
            checkOutput("fill", 32'(fill), 32'(m_cnt));
            if (stall_prev) checkOutput("hold_stable", 32'(word_out), 32'(held_word));
        end
        stall_prev = m_live && !rst && m_valid && !word_ready;
        held_word  = word_out;
        load       = 1'b0;
        if (rst) begin
            m_cnt   = 0;
            m_sr    = '0;
            m_valid = 1'b0;
            sb_q.delete();
            m_live  = 1'b1;
        end else if (m_live) begin
            word_fire = m_valid && word_ready;
            if (word_fire) begin
                checkOutput("sb_pop_available", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    checkOutput("word_out", 32'(word_out), 32'(sb_q.pop_front()));
                    words_popped++;
                end
            end
            if (abort) begin
                m_cnt = 0;
                m_sr  = '0;
            end else if (bit_valid && m_ready) begin
                m_sr[m_cnt] = bit_in;
                if (m_cnt == WIDTH - 1) begin
                    sb_q.push_back(m_sr);
                    load  = 1'b1;
                    m_cnt = 0;
                    m_sr  = '0;
                end else begin
                    m_cnt++;
                end
            end
            if (load) m_valid = 1'b1;
            else if (word_fire) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic bv, input logic b, input logic wr,
                                 input logic ab, input logic r);
        bit_valid  = bv;
        bit_in     = b;
        word_ready = wr;
        abort      = ab;
        rst        = r;
        tick();
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input logic wr);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b1, w[i], wr, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int cycles;
        rst        = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        abort      = 1'b0;
        word_ready = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("rst_word_valid", 32'(word_valid), 32'd0);
        checkOutput("rst_word_out", 32'(word_out), 32'h0);
        checkOutput("rst_fill", 32'(fill), 32'd0);
        checkOutput("rst_bit_ready", 32'(bit_ready), 32'd0);

        // T1: eight ones, one-cycle word_valid pulse
        sendWord(8'hFF, 1'b1);
        checkOutput("t1_valid", 32'(word_valid), 32'd1);
        checkOutput("t1_word", 32'(word_out), 32'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_pulse_end", 32'(word_valid), 32'd0);

        // T2: mixed pattern into the AND tree
        sendWord(8'h85, 1'b1);
        checkOutput("t2_word", 32'(word_out), 32'h85);
        checkOutput("t2_and_tree", 32'(&word_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T3: backpressure on the final bit, then same-edge consume and load
        sendWord(8'hFF, 1'b0);
        checkOutput("t3_held_valid", 32'(word_valid), 32'd1);
        for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_fill7", 32'(fill), 32'd7);
        bit_valid  = 1'b1;
        bit_in     = 1'b0;
        word_ready = 1'b0;
        abort      = 1'b0;
        #1;
        checkOutput("t3_ready_low", 32'(bit_ready), 32'd0);
        tick();
        checkOutput("t3_fill_hold", 32'(fill), 32'd7);
        checkOutput("t3_word_hold", 32'(word_out), 32'hFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_valid_stays", 32'(word_valid), 32'd1);
        checkOutput("t3_new_word", 32'(word_out), 32'h00);
        checkOutput("t3_fill0", 32'(fill), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_drained", 32'(word_valid), 32'd0);

        // T4: abort with a bit offered, then a clean word
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_fill3", 32'(fill), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_fill_abort", 32'(fill), 32'd0);
        checkOutput("t4_no_word", 32'(word_valid), 32'd0);
        sendWord(8'hFF, 1'b1);
        checkOutput("t4_word", 32'(word_out), 32'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T5: reset with a held word and a partial word
        sendWord(8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_fill5", 32'(fill), 32'd5);
        checkOutput("t5_held", 32'(word_out), 32'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_rst_valid", 32'(word_valid), 32'd0);
        checkOutput("t5_rst_word", 32'(word_out), 32'h0);
        checkOutput("t5_rst_fill", 32'(fill), 32'd0);
        sendWord(8'h5A, 1'b1);
        checkOutput("t5_clean_word", 32'(word_out), 32'h5A);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T6: random gaps on both sides against the scoreboard
        words_popped = 0;
        cycles       = 0;
        while (words_popped < 1000 && cycles < 50000) begin
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
            cycles++;
        end
        checkOutput("t6_word_count", 32'(words_popped >= 1000), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
